// File: rtl/usb_fifo_pkg.sv
// Shared types, default parameters and helpers for the packet FIFO.
package usb_fifo_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 64;
    localparam int DEF_AF_MARGIN = 4;
    localparam int DEF_AE_THRESH = 1;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // Index width for a power-of-two depth; pointers carry one extra wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one combinational read port.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage write; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/flex_pkt_fifo.sv
// Synchronous FIFO with speculative staging: words become visible to the reader only on commit.
module flex_pkt_fifo
    import usb_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_MARGIN = DEF_AF_MARGIN,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      clear,
    input  logic                      w_enable,
    input  logic [DATA_W-1:0]         w_data,
    input  logic                      commit,
    input  logic                      discard,
    input  logic                      r_enable,
    output logic [DATA_W-1:0]         r_data,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [ptr_width(DEPTH):0] count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W:0] DEPTH_P  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] AF_LVL_P = (PTR_W+1)'(DEPTH - AF_MARGIN);
    localparam logic [PTR_W:0] AE_LVL_P = (PTR_W+1)'(AE_THRESH);
    localparam logic [PTR_W:0] ZERO_P   = {(PTR_W+1){1'b0}};

    logic [PTR_W:0]    wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
    logic [PTR_W:0]    total_s, count_s, wr_inc_s, rd_inc_s;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              wr_acc_s, rd_acc_s, mem_we_s;
    logic [DATA_W-1:0] mem_rdata_s;
    fifo_status_t      status_s;

    // Modulo-2*DEPTH differences; the wrap bit separates full from empty.
    assign total_s  = wr_q - rd_q;
    assign count_s  = cm_q - rd_q;
    assign wr_inc_s = {{PTR_W{1'b0}}, wr_acc_s};
    assign rd_inc_s = {{PTR_W{1'b0}}, rd_acc_s};

    // Next-state for pointers and sticky errors: clear > discard > commit.
    always_comb begin
        wr_d     = wr_q;
        cm_d     = cm_q;
        rd_d     = rd_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        mem_we_s = 1'b0;
        wr_acc_s = w_enable && (total_s != DEPTH_P);
        rd_acc_s = r_enable && (count_s != ZERO_P);
        if (clear) begin
            wr_d  = ZERO_P;
            cm_d  = ZERO_P;
            rd_d  = ZERO_P;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            rd_d  = rd_q + rd_inc_s;
            unf_d = unf_q | (r_enable & ~rd_acc_s);
            if (discard) begin
                // A same-cycle write belongs to the dropped packet, so it is not an overflow.
                wr_d = cm_q;
            end else begin
                mem_we_s = wr_acc_s;
                wr_d     = wr_q + wr_inc_s;
                ovf_d    = ovf_q | (w_enable & ~wr_acc_s);
                if (commit) begin
                    cm_d = wr_q + wr_inc_s;
                end else begin
                    cm_d = cm_q;
                end
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_q <= ZERO_P;
            cm_q <= ZERO_P;
            rd_q <= ZERO_P;
        end else begin
            wr_q <= wr_d;
            cm_q <= cm_d;
            rd_q <= rd_d;
        end
    end

    // Sticky error flag registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we_s),
        .waddr_i (wr_q[PTR_W-1:0]),
        .wdata_i (w_data),
        .raddr_i (rd_q[PTR_W-1:0]),
        .rdata_o (mem_rdata_s)
    );

    // Status decode from registered pointers only.
    always_comb begin
        status_s.empty        = (count_s == ZERO_P);
        status_s.full         = (total_s == DEPTH_P);
        status_s.almost_full  = (total_s >= AF_LVL_P);
        status_s.almost_empty = (count_s <= AE_LVL_P);
        status_s.overflow     = ovf_q;
        status_s.underflow    = unf_q;
    end

    assign empty        = status_s.empty;
    assign full         = status_s.full;
    assign almost_full  = status_s.almost_full;
    assign almost_empty = status_s.almost_empty;
    assign overflow     = status_s.overflow;
    assign underflow    = status_s.underflow;
    assign count        = count_s;
    assign r_data       = status_s.empty ? {DATA_W{1'b0}} : mem_rdata_s;

endmodule

// File: tb/tb_flex_pkt_fifo.sv
// Directed bench for flex_pkt_fifo with a queue-based scoreboard of committed and staged words.
module tb_flex_pkt_fifo;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       clear = 1'b0;
    logic       w_enable = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       commit = 1'b0;
    logic       discard = 1'b0;
    logic       r_enable = 1'b0;
    logic [7:0] r_data;
    logic       empty, full, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;

    logic [7:0] cq [$];
    logic [7:0] sq [$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    flex_pkt_fifo #(
        .DATA_W    (8),
        .DEPTH     (8),
        .AF_MARGIN (2),
        .AE_THRESH (1)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .w_enable     (w_enable),
        .w_data       (w_data),
        .commit       (commit),
        .discard      (discard),
        .r_enable     (r_enable),
        .r_data       (r_data),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cq.delete();
        sq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic check_all(input string step);
        int tot;
        int cnt;
        tot = cq.size() + sq.size();
        cnt = cq.size();
        chk({step, ".empty"},  32'(empty),        32'(cnt == 0));
        chk({step, ".count"},  32'(count),        32'(cnt));
        chk({step, ".full"},   32'(full),         32'(tot == 8));
        chk({step, ".afull"},  32'(almost_full),  32'(tot >= 6));
        chk({step, ".aempty"}, 32'(almost_empty), 32'(cnt <= 1));
        chk({step, ".ovf"},    32'(overflow),     32'(m_ovf));
        chk({step, ".unf"},    32'(underflow),    32'(m_unf));
        chk({step, ".rdata"},  32'(r_data),       (cnt == 0) ? 32'h0 : 32'(cq[0]));
    endtask

    // One clock: update the scoreboard from the pre-edge state, clock, then compare.
    task automatic cyc(input logic we, input logic [7:0] wd, input logic cm, input logic dc,
                       input logic re, input logic cl, input string step);
        bit m_full;
        bit m_empty;
        w_enable = we; w_data = wd; commit = cm; discard = dc; r_enable = re; clear = cl;
        m_full  = (cq.size() + sq.size()) == 8;
        m_empty = (cq.size() == 0);
        if (cl) begin
            model_reset();
        end else begin
            if (re && m_empty) m_unf = 1'b1;
            if (re && !m_empty) void'(cq.pop_front());
            if (dc) begin
                sq.delete();
            end else begin
                if (we && m_full) m_ovf = 1'b1;
                if (we && !m_full) sq.push_back(wd);
                if (cm) begin
                    while (sq.size() > 0) cq.push_back(sq.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
        w_enable = 1'b0; commit = 1'b0; discard = 1'b0; r_enable = 1'b0; clear = 1'b0;
        check_all(step);
    endtask

    task automatic wr(input logic [7:0] d, input logic cm, input string step);
        cyc(1'b1, d, cm, 1'b0, 1'b0, 1'b0, step);
    endtask

    task automatic rd(input string step);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, step);
    endtask

    initial begin
        // Reset state.
        #3;
        check_all("rst0");
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic commit then reads.
        wr(8'hA1, 1'b0, "t2.w1");
        wr(8'hA2, 1'b0, "t2.w2");
        wr(8'hA3, 1'b1, "t2.w3c");
        rd("t2.r1");
        rd("t2.r2");
        rd("t2.r3");

        // Staged words are invisible; discard rewinds; fill to full then overflow.
        for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i), 1'b0, "t3.stage");
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "t3.discard");
        for (int i = 0; i < 8; i++) wr(8'hD0 + 8'(i), 1'b0, "t3.fill");
        wr(8'hEE, 1'b0, "t3.over");

        // Underflow on empty, then commit to make full, then clear everything.
        rd("t6.under");
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "t6.commit");
        rd("t6.pop");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "t6.clear");

        // Pointer wrap across index 0.
        for (int i = 0; i < 6; i++) wr(8'hB0 + 8'(i), (i == 5), "t4.w6");
        for (int i = 0; i < 6; i++) rd("t4.r6");
        for (int i = 0; i < 7; i++) wr(8'h70 + 8'(i), (i == 6), "t4.w7");
        wr(8'h7F, 1'b0, "t4.w8");
        wr(8'h99, 1'b1, "t4.fullcm");
        for (int i = 0; i < 8; i++) rd("t4.drain");

        // Commit and discard together: discard wins, write dropped.
        wr(8'h11, 1'b1, "t5.pre");
        wr(8'h22, 1'b0, "t5.stage");
        cyc(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, "t5.cmdc");
        rd("t5.r1");
        rd("t5.r2");

        // Simultaneous read and write, then async reset mid-packet.
        wr(8'h31, 1'b1, "t7.w");
        cyc(1'b1, 8'h32, 1'b1, 1'b0, 1'b1, 1'b0, "t7.rw");
        wr(8'h33, 1'b0, "t7.stage");
        #2;
        n_rst = 1'b0;
        model_reset();
        #1;
        check_all("t1.rst");
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("t1.post");
        wr(8'h44, 1'b1, "t1.w");
        rd("t1.r");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
